mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one parameter: MULT_CYCLES, default 5, multiply latency in clock cycles.
REQ-002 The block SHALL have one parameter: DIV_CYCLES, default 10, divide latency in clock cycles.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port start, input, 1 bit, SHALL request an operation in the current cycle.
REQ-006 Port op, input, 3 bits, SHALL select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
REQ-007 Port v1, input, 32 bits, SHALL carry operand 1 (multiplicand / dividend / mthi-mtlo data).
REQ-008 Port v2, input, 32 bits, SHALL carry operand 2 (multiplier / divisor).
REQ-009 Port cancel, input, 1 bit, SHALL abort an in-flight operation (see Configuration).
REQ-010 Port busy, output, 1 bit, SHALL be high while an operation is in flight.
REQ-011 Port hi, output, 32 bits, SHALL be the HI register.
REQ-012 Port lo, output, 32 bits, SHALL be the LO register.

Function
REQ-013 The block SHALL have states IDLE and RUN; busy SHALL equal (state == RUN), registered.
REQ-014 In IDLE, start=1 with op 0-3 at edge E0 SHALL latch op, v1 and v2, load a down-counter with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3), and enter RUN.
REQ-015 busy SHALL be high for exactly N cycles after E0; at edge E0+N the result SHALL be written to hi/lo, busy SHALL fall, and the state SHALL return to IDLE.
REQ-016 hi/lo SHALL hold their previous values throughout RUN.
REQ-017 Operands SHALL be sampled only at E0; later changes to v1/v2 SHALL have no effect.
REQ-018 mult SHALL compute the signed 64-bit product with {hi,lo}; multu SHALL compute the unsigned 64-bit product with {hi,lo}.
REQ-019 div SHALL set lo = signed quotient truncated toward zero and hi = remainder carrying the sign of the dividend; divu SHALL compute the unsigned equivalent.
REQ-020 On divide by zero, hi SHALL be v1 and lo SHALL be 32'hFFFFFFFF, for both div and divu, with the same latency.
REQ-021 div of 32'h80000000 by 32'hFFFFFFFF SHALL give lo = 32'h80000000 and hi = 0.
REQ-022 In IDLE, start with op 4 (mthi) or 5 (mtlo) SHALL write v1 to hi or lo at that edge; busy SHALL stay low.
REQ-023 start while busy=1 SHALL be ignored with no queuing; ops 6/7 SHALL change nothing.
REQ-024 A new start SHALL be accepted at the first edge at which busy is low, including the edge right after completion.

Reset
REQ-025 Assertion of reset SHALL immediately force hi=0, lo=0, busy=0, state=IDLE and counter=0, regardless of clk.
REQ-026 Reset during RUN SHALL discard the operation; no result SHALL be written.

Configuration
REQ-027 With macro MDU_CANCEL_EN defined, cancel=1 during RUN SHALL return the block to IDLE at the next edge, with busy low after that edge and hi/lo unchanged.
REQ-028 With MDU_CANCEL_EN defined, cancel SHALL take priority over completion on the same edge, and cancel in IDLE SHALL have no effect.
REQ-029 Without MDU_CANCEL_EN, port cancel SHALL exist but be ignored.

Verification
REQ-030 Scenario: mult v1=FFFFFFFF, v2=00000002 -> busy high 5 cycles, then hi=FFFFFFFF, lo=FFFFFFFE.
REQ-031 Scenario: multu with the same operands -> hi=00000001, lo=FFFFFFFE; a second start issued mid-run is ignored.
REQ-032 Scenario: div v1=FFFFFFF9 (-7), v2=00000002 -> busy 10 cycles, lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 Scenario: divu v1=7, v2=0 -> hi=00000007, lo=FFFFFFFF; then mtlo v1=1234 -> lo=1234 with no busy.
REQ-034 Scenario: reset pulsed 3 cycles into a div -> busy=0 and hi=lo=0 immediately; the next mult completes normally.
REQ-035 Scenario: with MDU_CANCEL_EN, cancel in cycle 2 of a mult -> busy low next edge, hi/lo keep their old values.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and fixed-latency multi-cycle operations.
// Optional macro MDU_CANCEL_EN enables aborting an in-flight operation via the cancel port.
module mdu #(
    parameter int unsigned MULT_CYCLES = 32'd5,
    parameter int unsigned DIV_CYCLES  = 32'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] hi_r, lo_r;
    logic        busy_r;
    logic        load_s, done_s, wr_hi_s, wr_lo_s, cancel_s;
    logic [63:0] res_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel;
`else
    logic unused_cancel_s;
    assign unused_cancel_s = cancel;
    assign cancel_s        = 1'b0;
`endif

    // Result as {hi, lo}; kind is the low two op bits (mult, multu, div, divu).
    function automatic logic [63:0] calc_result(input logic [1:0] kind,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0]        res;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        res = 64'd0;
        sq  = 32'sd0;
        sr  = 32'sd0;
        case (kind)
            2'd0: res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    // Overflow case: quotient wraps to the most negative value.
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    sq  = $signed(a) / $signed(b);
                    sr  = $signed(a) % $signed(b);
                    res = {sr, sq};
                end
            end
            2'd3: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    assign res_s = calc_result(op_r, a_r, b_r);

    // Next-state and control decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        done_s  = 1'b0;
        wr_hi_s = 1'b0;
        wr_lo_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (op[2] == 1'b0)) begin
                    state_s = RUN;
                    load_s  = 1'b1;
                    cnt_s   = op[1] ? DIV_CYCLES : MULT_CYCLES;
                end else if (start && (op == 3'd4)) begin
                    wr_hi_s = 1'b1;
                end else if (start && (op == 3'd5)) begin
                    wr_lo_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cancel_s) begin
                    state_s = IDLE;
                    cnt_s   = 32'd0;
                end else if (cnt_r <= 32'd1) begin
                    state_s = IDLE;
                    cnt_s   = 32'd0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 32'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 32'd0;
            end
        endcase
    end

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
            op_r    <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == RUN);
            if (load_s) begin
                op_r <= op[1:0];
                a_r  <= v1;
                b_r  <= v2;
            end else begin
                op_r <= op_r;
            end
            if (done_s) begin
                hi_r <= res_s[63:32];
                lo_r <= res_s[31:0];
            end else if (wr_hi_s) begin
                hi_r <= v1;
            end else if (wr_lo_s) begin
                lo_r <= v1;
            end else begin
                hi_r <= hi_r;
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
